lt24_bus_writer: RTL and testbench
==================================

# lt24_bus_writer

Write engine feeding the LT24 (ILI9341) 8080-style parallel bus driven by the LCD conduit of `soc_system`. It buffers command/data words from the upstream frame streamer or CSR path in a small FIFO, runs the panel hardware-reset/power-up sequence, and replays each word as a timed write cycle on `cs_n`/`wr_n`/`dc_n`/`d`. It sits directly upstream of the LT24 pins and consumes a valid/ready word stream.

## Interface
- `FIFO_DEPTH`, 8: word FIFO entries; power of two, ≥2.
- `WR_LOW_CYCLES`, 2: clocks `lcd_wr_n` is held low per write; ≥1.
- `WR_HIGH_CYCLES`, 2: clocks `lcd_wr_n` is held high after the low phase; ≥1.
- `RESET_CYCLES`, 500000: clocks `lcd_reset_n` is held low after `reset`; ≥1.
- `POST_RESET_CYCLES`, 6000000: clocks of wait after reset release before the first write; ≥1.

- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high reset.
- `in_data` in 16: word to write.
- `in_is_data` in 1: 1 = pixel/parameter data, 0 = command.
- `in_valid` in 1: upstream word valid.
- `in_ready` out 1: FIFO can accept.
- `lcd_on_req` in 1: backlight/panel enable request.
- `init_done` out 1: power-up sequence complete.
- `busy` out 1: FIFO non-empty or write cycle in progress.
- `lcd_cs_n`, `lcd_wr_n`, `lcd_rd_n`, `lcd_dc_n` out 1 each: bus strobes.
- `lcd_d` out 16: bus data.
- `lcd_reset_n` out 1: panel hardware reset.
- `lcd_on` out 1: panel power/backlight.

## Operation
- One clock; reset is synchronous and active-high.
- Transfer on `in_valid && in_ready`; FIFO stores `{in_is_data, in_data}` (17 bits). `in_ready = !full && !reset`, independent of `init_done`; words accepted during init are held until init completes.
- `lcd_rd_n` is constant 1 (write-only block).
- `lcd_on` = `lcd_on_req` registered one cycle, forced 0 while `init_done` = 0.
- FSM states:
  - RST: `lcd_reset_n` = 0; counts `RESET_CYCLES` then moves to WAIT.
  - WAIT: `lcd_reset_n` = 1; counts `POST_RESET_CYCLES` then moves to IDLE and sets `init_done`.
  - IDLE: `cs_n` = 1. If FIFO non-empty, pops, registers `lcd_d`/`lcd_dc_n` (= `in_is_data` of entry), and moves to SETUP.
  - SETUP: 1 cycle; `cs_n` = 0, `wr_n` = 1, data stable. Moves to WR_LO.
  - WR_LO: `wr_n` = 0 for `WR_LOW_CYCLES`. Moves to WR_HI.
  - WR_HI: `wr_n` = 1 for `WR_HIGH_CYCLES`. On the last cycle: if FIFO non-empty, pop and go to SETUP with `cs_n` kept 0; else go to IDLE.
- `lcd_d`/`lcd_dc_n` change only on a pop, never while `wr_n` = 0; they hold their last value in IDLE.
- Simultaneous push and pop on a full FIFO is allowed in the same cycle; on empty, a pushed word is not visible to the pop until the next cycle (no bypass).
- FIFO pointers wrap modulo `FIFO_DEPTH`; full/empty are tracked with an extra pointer bit.
- `busy` = FIFO non-empty OR state ∈ {SETUP, WR_LO, WR_HI}.

## Timing
- Reset values: `cs_n`=1, `wr_n`=1, `rd_n`=1, `dc_n`=1, `d`=0, `lcd_reset_n`=0, `lcd_on`=0, `init_done`=0, `busy`=0, `in_ready`=0 during reset and 1 on the first cycle after; FIFO empty; state RST.
- Reset asserted mid-write: the next cycle shows reset values, the FIFO is flushed, and the init sequence restarts.
- Word accepted at edge t into an empty FIFO while in IDLE: pop at t+1, SETUP in cycle t+1→t+2, `wr_n` falls at edge t+2.
- Sustained throughput: one word per `1 + WR_LOW_CYCLES + WR_HIGH_CYCLES` clocks (5 at defaults, i.e. 100 ns cycle, meeting the ILI9341 66 ns minimum).
- The panel latches on the rising edge of `wr_n`; data holds ≥ `WR_HIGH_CYCLES` clocks afterward.
- All outputs are registered; no combinational path from inputs to `lcd_*`.

## Structure
- `lt24_pkg`: FSM state enum, ILI9341 opcode constants (0x01 SWRESET, 0x11 SLPOUT, 0x29 DISPON, 0x2A CASET, 0x2B PASET, 0x2C RAMWR), and a FIFO entry width constant of 17.
- Sub-module `lt24_sync_fifo` (parameter `DEPTH`, `WIDTH`): single-clock FIFO with push/pop/full/empty. The FSM, counters and output registers live in `lt24_bus_writer`.

## Test plan
- Reset, with sim params `RESET_CYCLES`=4 and `POST_RESET_CYCLES`=6: `lcd_reset_n` is low exactly 4 cycles, `init_done` rises 6 cycles later, and no `wr_n` activity occurs before it.
- After init, push command 0x002C with `is_data`=0: `wr_n` falls 2 edges after acceptance and is low 2 cycles, with `dc_n`=0, `d`=0x002C, and `cs_n`=0 from SETUP through WR_HI, then 1.
- Push 20 data words 0x0000–0x0013 back-to-back: `in_ready` drops at 8 outstanding, all 20 appear in order at a 5-cycle period, `cs_n` stays low throughout, and `busy` clears after the last WR_HI.
- Push 3 words during WAIT: they are held, and are written in order starting 2 cycles after `init_done` rises.
- Assert `reset` during WR_LO of a burst: `wr_n`/`cs_n` return to 1 next cycle, the FIFO empties, `lcd_reset_n` goes 0, and the remaining words are never written.
- Toggle `lcd_on_req` before and after init: `lcd_on` stays 0 before `init_done`, then follows `lcd_on_req` with 1-cycle delay.

Source files
------------

// File: rtl/lt24_pkg.sv
`default_nettype none
// ============================================================================
// lt24_pkg -- shared types and constants for the LT24 (ILI9341) bus writer
// Rev 1.0
// ============================================================================
package lt24_pkg;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_SETUP = 3'd3,
    ST_WR_LO = 3'd4,
    ST_WR_HI = 3'd5
  } state_e;

  localparam logic [15:0] OP_SWRESET = 16'h0001;
  localparam logic [15:0] OP_SLPOUT  = 16'h0011;
  localparam logic [15:0] OP_DISPON  = 16'h0029;
  localparam logic [15:0] OP_CASET   = 16'h002A;
  localparam logic [15:0] OP_PASET   = 16'h002B;
  localparam logic [15:0] OP_RAMWR   = 16'h002C;

  // FIFO entry: {is_data, data[15:0]}
  localparam int ENTRY_W = 17;

endpackage
`default_nettype wire

// File: rtl/lt24_bus_writer_fifo.sv
`default_nettype none
// ============================================================================
// lt24_sync_fifo -- single-clock FIFO, pointers carry an extra wrap bit
// Rev 1.0
// ============================================================================
module lt24_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO may still take a word when the same cycle frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/lt24_bus_writer.sv
`default_nettype none
// ============================================================================
// lt24_bus_writer -- buffered ILI9341 8080-style write engine with power-up
// Rev 1.0
// ============================================================================
module lt24_bus_writer #(
  parameter int FIFO_DEPTH        = 8,
  parameter int WR_LOW_CYCLES     = 2,
  parameter int WR_HIGH_CYCLES    = 2,
  parameter int RESET_CYCLES      = 500000,
  parameter int POST_RESET_CYCLES = 6000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_is_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        lcd_on_req,
  output logic        init_done,
  output logic        busy,
  output logic        lcd_cs_n,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n,
  output logic        lcd_dc_n,
  output logic [15:0] lcd_d,
  output logic        lcd_reset_n,
  output logic        lcd_on
);

  import lt24_pkg::*;

  localparam logic [31:0] RST_LAST  = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] POST_LAST = 32'(POST_RESET_CYCLES - 1);
  localparam logic [31:0] LO_LAST   = 32'(WR_LOW_CYCLES - 1);
  localparam logic [31:0] HI_LAST   = 32'(WR_HIGH_CYCLES - 1);

  state_e             state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               cs_n_q, cs_n_d;
  logic               wr_n_q, wr_n_d;
  logic               dc_n_q, dc_n_d;
  logic [15:0]        d_q, d_d;
  logic               lcd_reset_n_q, lcd_reset_n_d;
  logic               init_done_q, init_done_d;
  logic               lcd_on_q, lcd_on_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_rdata;

  assign in_ready  = !fifo_full && !reset;
  assign fifo_push = in_valid && in_ready;

  lt24_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (fifo_push),
    .wdata ({in_is_data, in_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cs_n_d        = cs_n_q;
    wr_n_d        = wr_n_q;
    dc_n_d        = dc_n_q;
    d_d           = d_q;
    lcd_reset_n_d = lcd_reset_n_q;
    init_done_d   = init_done_q;
    fifo_pop      = 1'b0;

    case (state_q)
      ST_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d       = ST_WAIT;
          cnt_d         = '0;
          lcd_reset_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == POST_LAST) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_SETUP;
          cs_n_d   = 1'b0;
          d_d      = fifo_rdata[15:0];
          dc_n_d   = fifo_rdata[ENTRY_W-1];
        end
      end
      ST_SETUP: begin
        state_d = ST_WR_LO;
        wr_n_d  = 1'b0;
        cnt_d   = '0;
      end
      ST_WR_LO: begin
        if (cnt_q == LO_LAST) begin
          state_d = ST_WR_HI;
          wr_n_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_WR_HI: begin
        if (cnt_q == HI_LAST) begin
          cnt_d = '0;
          // Chain straight into the next word so cs_n stays asserted.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_SETUP;
            d_d      = fifo_rdata[15:0];
            dc_n_d   = fifo_rdata[ENTRY_W-1];
          end else begin
            state_d = ST_IDLE;
            cs_n_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = ST_RST;
    endcase

    lcd_on_d = lcd_on_req && init_done_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RST;
      cnt_q         <= '0;
      cs_n_q        <= 1'b1;
      wr_n_q        <= 1'b1;
      dc_n_q        <= 1'b1;
      d_q           <= '0;
      lcd_reset_n_q <= 1'b0;
      init_done_q   <= 1'b0;
      lcd_on_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cs_n_q        <= cs_n_d;
      wr_n_q        <= wr_n_d;
      dc_n_q        <= dc_n_d;
      d_q           <= d_d;
      lcd_reset_n_q <= lcd_reset_n_d;
      init_done_q   <= init_done_d;
      lcd_on_q      <= lcd_on_d;
    end
  end

  assign busy        = !fifo_empty ||
                       (state_q == ST_SETUP) || (state_q == ST_WR_LO) || (state_q == ST_WR_HI);
  assign lcd_cs_n    = cs_n_q;
  assign lcd_wr_n    = wr_n_q;
  assign lcd_rd_n    = 1'b1;
  assign lcd_dc_n    = dc_n_q;
  assign lcd_d       = d_q;
  assign lcd_reset_n = lcd_reset_n_q;
  assign init_done   = init_done_q;
  assign lcd_on      = lcd_on_q;

endmodule
`default_nettype wire

// File: tb/tb_lt24_bus_writer.sv
`default_nettype none
// ============================================================================
// tb_lt24_bus_writer -- self-checking bench for lt24_bus_writer
// Rev 1.0
// ============================================================================
module tb_lt24_bus_writer;
  import lt24_pkg::*;

  localparam int DEPTH  = 8;
  localparam int LO     = 2;
  localparam int HI     = 2;
  localparam int RSTC   = 4;
  localparam int POSTC  = 6;
  localparam int PERIOD = 1 + LO + HI;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_is_data = 1'b0;
  logic        in_valid = 1'b0;
  logic        lcd_on_req = 1'b0;
  logic        in_ready, init_done, busy;
  logic        lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_dc_n, lcd_reset_n, lcd_on;
  logic [15:0] lcd_d;

  lt24_bus_writer #(
    .FIFO_DEPTH        (DEPTH),
    .WR_LOW_CYCLES     (LO),
    .WR_HIGH_CYCLES    (HI),
    .RESET_CYCLES      (RSTC),
    .POST_RESET_CYCLES (POSTC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_is_data  (in_is_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .lcd_on_req  (lcd_on_req),
    .init_done   (init_done),
    .busy        (busy),
    .lcd_cs_n    (lcd_cs_n),
    .lcd_wr_n    (lcd_wr_n),
    .lcd_rd_n    (lcd_rd_n),
    .lcd_dc_n    (lcd_dc_n),
    .lcd_d       (lcd_d),
    .lcd_reset_n (lcd_reset_n),
    .lcd_on      (lcd_on)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: accepted words with acceptance edge; observed bus writes.
  logic [16:0] acc_w[$];
  int          acc_t[$];
  logic [16:0] obs_w[$];
  int          obs_f[$];
  int          obs_lo[$];
  int          init_edge = -1000;
  int          data_glitch = 0, cs_bad = 0, early_wr = 0, cs_rise = 0;

  logic        prev_wr = 1'b1, prev_cs = 1'b1, prev_dc = 1'b1, prev_init = 1'b0;
  logic [15:0] prev_d = '0;
  int          fall_t = 0, lo_len = 0;

  always @(negedge clk) begin
    if (lcd_wr_n === 1'b0) begin
      lo_len++;
      if (lcd_cs_n !== 1'b0) cs_bad++;
      if (!prev_wr && (lcd_d !== prev_d || lcd_dc_n !== prev_dc)) data_glitch++;
      if (prev_wr) begin
        fall_t = cyc;
        if (init_done !== 1'b1) early_wr++;
      end
    end else if (!prev_wr) begin
      if (lcd_cs_n === 1'b0) begin
        obs_w.push_back({lcd_dc_n, lcd_d});
        obs_f.push_back(fall_t);
        obs_lo.push_back(lo_len);
      end
      lo_len = 0;
    end
    if (init_done === 1'b1 && !prev_init) init_edge = cyc;
    if (lcd_cs_n === 1'b1 && !prev_cs) cs_rise++;
    prev_wr   = (lcd_wr_n !== 1'b0);
    prev_cs   = (lcd_cs_n === 1'b1);
    prev_init = (init_done === 1'b1);
    prev_d    = lcd_d;
    prev_dc   = lcd_dc_n;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rec(input logic [16:0] w);
    acc_w.push_back(w);
    acc_t.push_back(cyc);
  endtask

  task automatic clear_model();
    acc_w.delete();
    acc_t.delete();
    obs_w.delete();
    obs_f.delete();
    obs_lo.delete();
  endtask

  // Write k falls at max(accept+2, previous fall + period, init edge + 2).
  function automatic int fifo_level(input int now);
    int prev = -1000;
    int f;
    int lvl = 0;
    for (int i = 0; i < acc_t.size(); i++) begin
      f = acc_t[i] + 2;
      if (prev + PERIOD > f) f = prev + PERIOD;
      if (init_edge + 2 > f) f = init_edge + 2;
      prev = f;
      if (f - 1 > now) lvl++;
    end
    return lvl;
  endfunction

  task automatic check_writes();
    int prev = -1000;
    int f;
    chk("wr_count", 32'(obs_w.size()), 32'(acc_w.size()));
    for (int i = 0; i < acc_w.size() && i < obs_w.size(); i++) begin
      f = acc_t[i] + 2;
      if (prev + PERIOD > f) f = prev + PERIOD;
      if (init_edge + 2 > f) f = init_edge + 2;
      prev = f;
      chk("wr_word", 32'(obs_w[i]), 32'(acc_w[i]));
      chk("wr_fall", 32'(obs_f[i]), 32'(f));
      chk("wr_low_len", 32'(obs_lo[i]), 32'(LO));
    end
    clear_model();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(n < 300), 32'd1);
  endtask

  initial begin
    int          n, lvl, idx, c0;
    logic [16:0] w;
    logic        take, saw_full;
    logic [5:0]  wr_pat, cs_pat, busy_pat;

    lcd_on_req = 1'b1;
    repeat (3) tick();
    chk("rst_cs_n", 32'(lcd_cs_n), 32'd1);
    chk("rst_wr_n", 32'(lcd_wr_n), 32'd1);
    chk("rst_rd_n", 32'(lcd_rd_n), 32'd1);
    chk("rst_dc_n", 32'(lcd_dc_n), 32'd1);
    chk("rst_d", 32'(lcd_d), 32'd0);
    chk("rst_lcd_reset_n", 32'(lcd_reset_n), 32'd0);
    chk("rst_lcd_on", 32'(lcd_on), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Power-up sequence timing
    n = 1;
    while (!lcd_reset_n && n < 50) begin
      tick();
      chk("pre_init_lcd_on", 32'(lcd_on), 32'd0);
      if (!lcd_reset_n) n++;
    end
    chk("reset_n_low_cycles", 32'(n), 32'(RSTC));
    n = 0;
    while (!init_done && n < 50) begin
      chk("wait_lcd_on", 32'(lcd_on), 32'd0);
      tick();
      n++;
    end
    chk("init_delay", 32'(n), 32'(POSTC));
    chk("no_early_writes", 32'(early_wr), 32'd0);
    chk("lcd_on_after_init", 32'(lcd_on), 32'd1);

    lcd_on_req = 1'b0;
    #1;
    chk("lcd_on_hold", 32'(lcd_on), 32'd1);
    tick();
    chk("lcd_on_fall", 32'(lcd_on), 32'd0);
    lcd_on_req = 1'b1;
    tick();
    chk("lcd_on_rise", 32'(lcd_on), 32'd1);

    // Single command write, cycle by cycle
    in_data = OP_RAMWR;
    in_is_data = 1'b0;
    in_valid = 1'b1;
    chk("cmd_ready", 32'(in_ready), 32'd1);
    tick();
    push_rec({1'b0, OP_RAMWR});
    in_valid = 1'b0;
    chk("cmd_busy_accept", 32'(busy), 32'd1);
    wr_pat   = 6'b111001;
    cs_pat   = 6'b100000;
    busy_pat = 6'b011111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("cmd_wr_n", 32'(lcd_wr_n), 32'(wr_pat[k]));
      chk("cmd_cs_n", 32'(lcd_cs_n), 32'(cs_pat[k]));
      chk("cmd_busy", 32'(busy), 32'(busy_pat[k]));
    end
    chk("cmd_d_held", 32'(lcd_d), 32'(OP_RAMWR));
    chk("cmd_dc_n_held", 32'(lcd_dc_n), 32'd0);
    check_writes();

    // 20-word back-to-back data burst
    c0 = cs_rise;
    idx = 0;
    n = 0;
    saw_full = 1'b0;
    while (idx < 20 && n < 400) begin
      in_valid = 1'b1;
      in_is_data = 1'b1;
      in_data = 16'(idx);
      lvl = fifo_level(cyc);
      chk("burst_in_ready", 32'(in_ready), 32'(lvl < DEPTH));
      if (lvl >= DEPTH) saw_full = 1'b1;
      take = (lvl < DEPTH);
      tick();
      n++;
      if (take) begin
        push_rec({1'b1, 16'(idx)});
        idx++;
      end
    end
    in_valid = 1'b0;
    chk("burst_filled", 32'(saw_full), 32'd1);
    wait_idle();
    chk("burst_cs_rises", 32'(cs_rise - c0), 32'd1);
    chk("burst_cs_idle", 32'(lcd_cs_n), 32'd1);
    check_writes();

    // Random words with random valid gaps
    idx = 0;
    n = 0;
    w = 17'($urandom);
    while (idx < 40 && n < 1500) begin
      in_valid = ($urandom_range(0, 9) < 7);
      {in_is_data, in_data} = w;
      lvl = fifo_level(cyc);
      chk("rnd_in_ready", 32'(in_ready), 32'(lvl < DEPTH));
      take = in_valid && (lvl < DEPTH);
      tick();
      n++;
      if (take) begin
        push_rec(w);
        idx++;
        w = 17'($urandom);
      end
    end
    in_valid = 1'b0;
    chk("rnd_all_pushed", 32'(idx), 32'd40);
    wait_idle();
    check_writes();

    // Words pushed during WAIT are held until init completes
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    clear_model();
    n = 0;
    while (!lcd_reset_n && n < 50) begin
      tick();
      n++;
    end
    chk("wait_reached", 32'(n < 50), 32'd1);
    for (int k = 0; k < 3; k++) begin
      w = 17'($urandom);
      {in_is_data, in_data} = w;
      in_valid = 1'b1;
      chk("wait_in_ready", 32'(in_ready), 32'd1);
      tick();
      push_rec(w);
    end
    in_valid = 1'b0;
    chk("wait_not_init", 32'(init_done), 32'd0);
    chk("wait_held", 32'(obs_w.size()), 32'd0);
    n = 0;
    while (!init_done && n < 50) begin
      tick();
      n++;
    end
    chk("wait_init_timeout", 32'(n < 50), 32'd1);
    wait_idle();
    check_writes();

    // Reset during WR_LO of the third word of a burst
    n = 0;
    idx = 0;
    while (!(obs_w.size() == 2 && !lcd_wr_n) && n < 200) begin
      in_valid = (idx < 8);
      in_is_data = 1'b1;
      in_data = 16'h0100 + 16'(idx);
      take = in_valid && in_ready;
      tick();
      n++;
      if (take) idx++;
    end
    chk("midwr_reached", 32'(n < 200), 32'd1);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("midwr_wr_n", 32'(lcd_wr_n), 32'd1);
    chk("midwr_cs_n", 32'(lcd_cs_n), 32'd1);
    chk("midwr_lcd_reset_n", 32'(lcd_reset_n), 32'd0);
    chk("midwr_busy", 32'(busy), 32'd0);
    chk("midwr_init_done", 32'(init_done), 32'd0);
    chk("midwr_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("midwr_flushed_ready", 32'(in_ready), 32'd1);
    clear_model();
    n = 0;
    while (!init_done && n < 50) begin
      tick();
      n++;
    end
    chk("midwr_reinit", 32'(n < 50), 32'd1);
    repeat (20) tick();
    chk("midwr_no_writes", 32'(obs_w.size()), 32'd0);
    chk("midwr_idle_busy", 32'(busy), 32'd0);

    chk("data_stable_wr_low", 32'(data_glitch), 32'd0);
    chk("cs_low_during_wr", 32'(cs_bad), 32'd0);
    chk("no_writes_before_init", 32'(early_wr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
